cnn_window_feeder: RTL and testbench



---
 rtl/cnn_window_feeder_if.sv | 21 ++
 rtl/cnn_window_feeder.sv | 110 +++++++++++
 tb/tb_cnn_window_feeder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cnn_window_feeder_if.sv
// cnn_window_feeder_if: pixel-in / 3x3-window-out handshake bundle for the CNN window feeder.
// The frame_done/frame_cnt signals exist only when CNN_WIN_STATS_EN is defined.
interface cnn_window_feeder_if #(parameter int DATA_W = 9);
  logic in_valid, in_ready, out_valid, out_ready, out_last;
  logic signed [DATA_W-1:0] in_data, W1, W2, W3, W4, W5, W6, W7, W8, W9;
`ifdef CNN_WIN_STATS_EN
  logic frame_done;
  logic [15:0] frame_cnt;
  modport master(input in_valid, in_data, out_ready,
                 output in_ready, out_valid, out_last, W1, W2, W3, W4, W5, W6, W7, W8, W9,
                 frame_done, frame_cnt);
  modport slave(output in_valid, in_data, out_ready,
                input in_ready, out_valid, out_last, W1, W2, W3, W4, W5, W6, W7, W8, W9,
                frame_done, frame_cnt);
`else
  modport master(input in_valid, in_data, out_ready,
                 output in_ready, out_valid, out_last, W1, W2, W3, W4, W5, W6, W7, W8, W9);
  modport slave(output in_valid, in_data, out_ready,
                input in_ready, out_valid, out_last, W1, W2, W3, W4, W5, W6, W7, W8, W9);
`endif
endinterface

// File: rtl/cnn_window_feeder.sv
// cnn_window_feeder: raster pixel stream to zero-padded 3x3 windows via two line buffers.
// Optional CNN_WIN_STATS_EN adds frame_done pulse and 16-bit frame_cnt.
module cnn_window_feeder #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int DATA_W = 9
) (
  input logic clk,
  input logic rst_n,
  cnn_window_feeder_if.master bus
);
  localparam int N    = IMG_W * IMG_H;
  localparam int LAST = N + IMG_W;
  localparam int PW   = $clog2(LAST + 1);
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic [CW-1:0] pc_q, pc_d, cc_q, cc_d;
  logic [RW-1:0] cr_q, cr_d;
  logic alive_q, ov_q, ov_d, last_q, last_d;
  logic free, take, emit, fin, top, bot, lft, rgt;
  logic signed [DATA_W-1:0] din;
  logic signed [DATA_W-1:0] lb_a [IMG_W];
  logic signed [DATA_W-1:0] lb_b [IMG_W];
  logic signed [DATA_W-1:0] s_q [9];
  logic signed [DATA_W-1:0] n [9];
  logic signed [DATA_W-1:0] m [9];
  logic signed [DATA_W-1:0] w_q [9];
  assign free = !ov_q || bus.out_ready;
  assign bus.in_ready = alive_q && state_q != FLUSH && free;
  assign take = state_q == FLUSH ? free : bus.in_valid && bus.in_ready;
  assign emit = take && state_q != FILL;
  assign fin = take && state_q == FLUSH && p_q == PW'(LAST);
  assign din = state_q == FLUSH ? '0 : bus.in_data;
  // Raw window shifts left; new right column is (row-2, row-1, incoming) at the input column
  assign n = '{s_q[1], s_q[2], lb_b[pc_q], s_q[4], s_q[5], lb_a[pc_q], s_q[7], s_q[8], din};
  assign top = cr_q == '0;
  assign bot = cr_q == RW'(IMG_H - 1);
  assign lft = cc_q == '0;
  assign rgt = cc_q == CW'(IMG_W - 1);
  always_comb begin
    for (int i = 0; i < 9; i++)
      m[i] = ((i < 3 && top) || (i > 5 && bot) || (i % 3 == 0 && lft) || (i % 3 == 2 && rgt)) ? '0 : n[i];
  end
  always_comb begin
    state_d = !take ? state_q :
              (state_q == FILL && p_q == PW'(IMG_W)) ? RUN :
              (state_q == RUN && p_q == PW'(N - 1)) ? FLUSH :
              fin ? FILL : state_q;
    p_d     = !take ? p_q : fin ? '0 : p_q + 1'b1;
    pc_d    = !take ? pc_q : (fin || pc_q == CW'(IMG_W - 1)) ? '0 : pc_q + 1'b1;
    cc_d    = fin ? '0 : !emit ? cc_q : rgt ? '0 : cc_q + 1'b1;
    cr_d    = fin ? '0 : (emit && rgt) ? cr_q + 1'b1 : cr_q;
    ov_d    = emit || (ov_q && !bus.out_ready);
    last_d  = emit ? fin : last_q && ov_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      p_q     <= '0;
      pc_q    <= '0;
      cc_q    <= '0;
      cr_q    <= '0;
      alive_q <= 1'b0;
      ov_q    <= 1'b0;
      last_q  <= 1'b0;
      w_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      pc_q    <= pc_d;
      cc_q    <= cc_d;
      cr_q    <= cr_d;
      alive_q <= 1'b1;
      ov_q    <= ov_d;
      last_q  <= last_d;
      if (emit) w_q <= m;
    end
  end
  // Line buffers and raw window are never reset; padding masks hide stale data
  always_ff @(posedge clk) begin
    if (take) begin
      lb_b[pc_q] <= lb_a[pc_q];
      lb_a[pc_q] <= din;
      s_q        <= n;
    end
  end
  assign bus.out_valid = ov_q;
  assign bus.out_last  = last_q;
  assign bus.W1 = w_q[0];
  assign bus.W2 = w_q[1];
  assign bus.W3 = w_q[2];
  assign bus.W4 = w_q[3];
  assign bus.W5 = w_q[4];
  assign bus.W6 = w_q[5];
  assign bus.W7 = w_q[6];
  assign bus.W8 = w_q[7];
  assign bus.W9 = w_q[8];
`ifdef CNN_WIN_STATS_EN
  logic [15:0] frame_cnt_q;
  assign bus.frame_done = ov_q && bus.out_ready && last_q;
  assign bus.frame_cnt  = frame_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else if (bus.frame_done) frame_cnt_q <= frame_cnt_q + 1'b1;
  end
`endif
endmodule

// File: tb/tb_cnn_window_feeder.sv
// tb_cnn_window_feeder: drives 4x3 frames and checks every window against a padded-neighbourhood model.
module tb_cnn_window_feeder;
  localparam int W = 4, H = 3, N = W * H;
  localparam logic [80:0] E0  = {9'd0, 9'd0, 9'd0, 9'd0, 9'd1, 9'd2, 9'd0, 9'd5, 9'd6};
  localparam logic [80:0] E5  = {9'd1, 9'd2, 9'd3, 9'd5, 9'd6, 9'd7, 9'd9, 9'd10, 9'd11};
  localparam logic [80:0] E11 = {9'd7, 9'd8, 9'd0, 9'd11, 9'd12, 9'd0, 9'd0, 9'd0, 9'd0};
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  cnn_window_feeder_if #(.DATA_W(9)) bus();
  cnn_window_feeder #(.IMG_W(W), .IMG_H(H), .DATA_W(9)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int compared = 0, mismatched = 0;
  logic signed [8:0] img [N];
  int acc_n = 0, win_n = 0, frame_wins, stepno = 0, acc6_step, first_ov_step, sent, gap;
  bit acc, xfer, ir_s, ov_s, const_chk, gap_done, stalled;
  logic [80:0] w_obs, w_s, snap;
  logic signed [8:0] px;
  logic rdy;
  assign w_obs = {bus.W1, bus.W2, bus.W3, bus.W4, bus.W5, bus.W6, bus.W7, bus.W8, bus.W9};

  task automatic chk(input string tag, input logic [80:0] obs, input logic [80:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [80:0] model_win(int k);
    logic [80:0] v = '0;
    for (int j = 0; j < 9; j++) begin
      int r = k / W + j / 3 - 1;
      int c = k % W + j % 3 - 1;
      v[80 - 9 * j -: 9] = (r < 0 || r >= H || c < 0 || c >= W) ? 9'd0 : img[r * W + c];
    end
    return v;
  endfunction

  task step(input logic v, input logic signed [8:0] d, input logic r);
    bus.in_valid = v;
    bus.in_data = d;
    bus.out_ready = r;
    #1;
    ir_s = bus.in_ready;
    ov_s = bus.out_valid;
    w_s = w_obs;
    acc = bus.in_valid && bus.in_ready;
    xfer = bus.out_valid && bus.out_ready;
    if (bus.out_valid && first_ov_step < 0) first_ov_step = stepno;
    if (xfer) begin
      chk("window", w_obs, model_win(win_n));
      chk("out_last", bus.out_last, win_n == N - 1);
      if (const_chk && win_n == 0) chk("win_c00", w_obs, E0);
      if (const_chk && win_n == 5) chk("win_c11", w_obs, E5);
      if (const_chk && win_n == 11) chk("win_c23", w_obs, E11);
      win_n = win_n == N - 1 ? 0 : win_n + 1;
      frame_wins++;
    end
    if (acc) begin
      if (acc_n == N) acc_n = 0;
      img[acc_n] = d;
      acc_n++;
      if (acc_n == 6 && acc6_step < 0) acc6_step = stepno;
    end
    stepno++;
    @(negedge clk);
  endtask

  // kind 0: ramp 1..N; 1: random with a 10-cycle stall; 2: extremes with random out_ready
  task run_frame(input int kind);
    sent = 0; frame_wins = 0; acc6_step = -1; first_ov_step = -1;
    gap = 0; gap_done = 0; stalled = 0; const_chk = kind == 0;
    for (int g = 0; g < 300 && frame_wins < N; g++) begin
      if (sent < N) begin
        px = kind == 0 ? 9'(sent + 1) :
             kind == 1 ? 9'($urandom) :
             sent % 3 == 0 ? 9'h100 : sent % 3 == 1 ? 9'h0FF : 9'($urandom);
        rdy = kind == 2 ? ($urandom_range(3) != 0) : 1'b1;
        if (kind == 1 && sent == 7 && !stalled) begin
          stalled = 1;
          for (int s = 0; s < 10; s++) begin
            step(1'b1, px, 1'b0);
            if (s == 0) begin snap = w_s; chk("stall_ov", ov_s, 1'b1); end
            chk("stall_ready", ir_s, 1'b0);
            chk("stall_hold", w_s, snap);
          end
        end
        step(1'b1, px, rdy);
        if (acc) sent++;
      end else begin
        step(1'b0, '0, 1'b1);
        if (!gap_done) begin
          if (ir_s) gap_done = 1;
          else gap++;
        end
      end
    end
    chk("frame_windows", frame_wins, N);
    if (kind == 0) begin
      chk("first_valid", first_ov_step, acc6_step + 1);
      chk("flush_gap", gap, W + 1);
    end
  endtask

  initial begin
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_last", bus.out_last, 1'b0);
    chk("rst_window", w_obs, '0);
    chk("rst_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1;
    run_frame(0);
    run_frame(1);
    run_frame(2);
    sent = 0;
    for (int g = 0; g < 50 && sent < 7; g++) begin
      step(1'b1, 9'($urandom), 1'b1);
      if (acc) sent++;
    end
    chk("pre_rst_valid", bus.out_valid, 1'b1);
    #2 rst_n = 0;
    #1 chk("async_drop", bus.out_valid, 1'b0);
    chk("rst_ready2", bus.in_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    acc_n = 0;
    win_n = 0;
    run_frame(0);
`ifdef CNN_WIN_STATS_EN
    chk("frame_cnt", bus.frame_cnt, 1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
